// File: rtl/mem_a_loader_if.sv
// Loader-side bundle: upstream valid/ready stream, memory A write port and transfer-controller handshake.
// The cksum signal exists only when LOADER_CKSUM_EN is defined.
interface mem_a_loader_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          WEA;
  logic [AW-1:0] AddrA;
  logic [DW-1:0] DataInA;
  logic          start;
  logic          xfer_done;
  logic          busy;
`ifdef LOADER_CKSUM_EN
  logic [DW-1:0] cksum;

  modport master (
    input  in_valid, in_data, xfer_done,
    output in_ready, WEA, AddrA, DataInA, start, busy, cksum
  );
  modport slave (
    output in_valid, in_data, xfer_done,
    input  in_ready, WEA, AddrA, DataInA, start, busy, cksum
  );
`else
  modport master (
    input  in_valid, in_data, xfer_done,
    output in_ready, WEA, AddrA, DataInA, start, busy
  );
  modport slave (
    output in_valid, in_data, xfer_done,
    input  in_ready, WEA, AddrA, DataInA, start, busy
  );
`endif
endinterface

// File: rtl/mem_a_loader.sv
// Fills memory A with DEPTH consecutive stream words, pulses start, then waits for xfer_done.
// Optional LOADER_CKSUM_EN adds a running mod-2**DW checksum of the current batch.
module mem_a_loader #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic           clock,
  input  logic           Reset,
  mem_a_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAST_WR,
    START,
    WAIT_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg;
  logic          wea_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic          in_ready_c;
  logic          start_c;
  logic          busy_c;
  logic          accept;

  assign accept = bus.in_valid & in_ready_c;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready_c = 1'b0;
    start_c    = 1'b0;
    busy_c     = 1'b0;
    case (state_reg)
      IDLE: state_next = FILL;
      FILL: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && (cnt_reg == AW'(DEPTH - 1))) begin
          state_next = LAST_WR;
        end
      end
      LAST_WR: begin
        busy_c     = 1'b1;
        state_next = START;
      end
      START: begin
        busy_c     = 1'b1;
        start_c    = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy_c = 1'b1;
        if (bus.xfer_done) begin
          state_next = FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port is registered: an accept at edge N shows up as a write during cycle N+1.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cnt_reg  <= '0;
      wea_reg  <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      wea_reg <= accept;
      if (accept) begin
        addr_reg <= cnt_reg;
        data_reg <= bus.in_data;
        cnt_reg  <= cnt_reg + AW'(1);
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [DW-1:0] cksum_reg;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cksum_reg <= '0;
    end else if ((state_reg == WAIT_DONE) && bus.xfer_done) begin
      cksum_reg <= '0;
    end else if (accept) begin
      cksum_reg <= cksum_reg + bus.in_data;
    end
  end

  assign bus.cksum = cksum_reg;
`endif

  assign bus.in_ready = in_ready_c;
  assign bus.start    = start_c;
  assign bus.busy     = busy_c;
  assign bus.WEA      = wea_reg;
  assign bus.AddrA    = addr_reg;
  assign bus.DataInA  = data_reg;

endmodule

// File: tb/tb_mem_a_loader.sv
// Randomized + directed bench for mem_a_loader against a batch-level reference model.
// Define LOADER_CKSUM_EN to also check the checksum port.
module tb_mem_a_loader;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic Reset = 1'b0;

  mem_a_loader_if #(.DW(DW), .AW(AW)) bus ();

  mem_a_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words accepted in the current batch, and cycles elapsed since handoff
  // (0 = filling, 1 = last write, 2 = start pulse, 3 = waiting for xfer_done).
  logic [DW-1:0] batch_q[$];
  bit            m_live;
  int            m_post;
  bit            m_wea;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            obs_starts;
  int            exp_starts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] batch_sum();
    logic [DW-1:0] s = '0;
    foreach (batch_q[i]) s = s + batch_q[i];
    return s;
  endfunction

  function automatic bit m_ready();
    return m_live && (m_post == 0);
  endfunction

  task automatic model_reset();
    batch_q.delete();
    m_live = 0;
    m_post = 0;
    m_wea  = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Predicts the effect of the coming rising edge given the inputs just driven.
  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit x);
    m_wea = 0;
    if (!m_live) begin
      m_live = 1;
    end else if (m_post == 0) begin
      if (v) begin
        m_wea  = 1;
        m_addr = AW'(batch_q.size());
        m_data = d;
        batch_q.push_back(d);
        if (batch_q.size() == DEPTH) m_post = 1;
      end
    end else if (m_post < 3) begin
      m_post++;
    end else if (x) begin
      batch_q.delete();
      m_post = 0;
    end
  endtask

  task automatic compare_all();
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready()});
    check("WEA", {31'd0, bus.WEA}, {31'd0, m_wea});
    check("AddrA", 32'(bus.AddrA), 32'(m_addr));
    check("DataInA", 32'(bus.DataInA), 32'(m_data));
    check("start", {31'd0, bus.start}, {31'd0, (m_post == 2)});
    check("busy", {31'd0, bus.busy}, {31'd0, (m_post != 0)});
`ifdef LOADER_CKSUM_EN
    check("cksum", 32'(bus.cksum), 32'(batch_sum()));
`endif
    if (bus.start) obs_starts++;
    if (m_post == 2) exp_starts++;
    if (bus.WEA) $display("write addr=%0d data=%02h", bus.AddrA, bus.DataInA);
  endtask

  // One clock: drive inputs at the falling edge, predict, then compare at the next falling edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit x);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.xfer_done = x;
    model_edge(v, d, x);
    @(negedge clock);
    compare_all();
  endtask

  // Hold a word on the stream until the loader takes it.
  task automatic send(input logic [DW-1:0] d, input bit x);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      done = m_ready();
      cycle(1'b1, d, x);
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Idle until the handoff reaches the waiting phase, then return with one xfer_done pulse.
  task automatic finish_batch();
    for (int k = 0; k < 50 && m_post != 3; k++) cycle(1'b0, '0, 1'b0);
    if (m_post != 3) check("wait_timeout", 32'(m_post), 32'd3);
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic async_reset_check();
    @(posedge clock);
    #2;
    Reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_WEA", {31'd0, bus.WEA}, 32'd0);
    check("rst_AddrA", 32'(bus.AddrA), 32'd0);
    check("rst_DataInA", 32'(bus.DataInA), 32'd0);
    check("rst_start", {31'd0, bus.start}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef LOADER_CKSUM_EN
    check("rst_cksum", 32'(bus.cksum), 32'd0);
`endif
    model_reset();
    @(negedge clock);
    Reset = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.xfer_done = 1'b0;
    obs_starts    = 0;
    exp_starts    = 0;
    model_reset();

    // Power-on reset
    #1;
    check("por_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("por_WEA", {31'd0, bus.WEA}, 32'd0);
    check("por_start", {31'd0, bus.start}, 32'd0);
    check("por_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    Reset = 1'b1;

    // Back-to-back words 0..7
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
    for (int k = 0; k < 10 && m_post != 2; k++) cycle(1'b0, '0, 1'b0);
    check("b1_start_phase", {31'd0, bus.start}, 32'd1);
`ifdef LOADER_CKSUM_EN
    check("b1_cksum", 32'(bus.cksum), 32'h1C);
`endif

    // Upstream pushes 0xAA while waiting; a 3-cycle xfer_done gives a single return
    for (int k = 0; k < 10; k++) cycle(1'b1, 8'hAA, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'hAA, 1'b1);
    check("aa_busy_clear", {31'd0, bus.busy}, 32'd0);
    while (m_post == 0 && batch_q.size() < DEPTH) send(8'hAA, 1'b0);
    finish_batch();

    // Bubbled stream 0x10..0x17
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(8'h10 + i), 1'b0);
      cycle(1'b0, '0, 1'b0);
    end
    finish_batch();

    // xfer_done asserted while filling must be ignored
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0);
    for (int i = 4; i < DEPTH; i++) send(8'(8'h40 + i), 1'b1);
    finish_batch();

    // Asynchronous reset in mid-batch
    for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 1'b0);
    async_reset_check();
    send(8'h55, 1'b0);
    check("post_rst_first_addr", 32'(bus.AddrA), 32'd0);
    for (int i = 1; i < DEPTH; i++) send(8'(i), 1'b0);
    finish_batch();

    // All-ones batch, then checksum restart
    for (int i = 0; i < DEPTH; i++) send(8'hFF, 1'b0);
    for (int k = 0; k < 10 && m_post != 3; k++) cycle(1'b0, '0, 1'b0);
`ifdef LOADER_CKSUM_EN
    check("ff_cksum", 32'(bus.cksum), 32'hF8);
`endif
    cycle(1'b0, '0, 1'b1);
    send(8'h01, 1'b0);
`ifdef LOADER_CKSUM_EN
    check("restart_cksum", 32'(bus.cksum), 32'h01);
`endif
    for (int i = 1; i < DEPTH; i++) send(8'($urandom), 1'b0);
    finish_batch();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0));
    end

    check("start_pulses", 32'(obs_starts), 32'(exp_starts));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
